// File: rtl/lcd1602_pkg.sv
// lcd1602_pkg: HD44780 command encodings, DDRAM geometry, FSM states and the address-counter step
package lcd1602_pkg;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_HOME     = 8'h02;
  localparam logic [7:0] CMD_ENTRY    = 8'h04;
  localparam logic [7:0] CMD_DISPCTL  = 8'h08;
  localparam logic [7:0] CMD_FUNCSET  = 8'h20;
  localparam logic [7:0] CMD_SETDDRAM = 8'h80;
  localparam logic [6:0] LINE0_BASE = 7'h00;
  localparam logic [6:0] LINE1_BASE = 7'h40;
  localparam logic [6:0] WRAP_HI0   = 7'h27;
  localparam logic [6:0] WRAP_HI1   = 7'h67;
  localparam logic [6:0] LINE_CHARS = 7'd16;
  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_CLEAR} state_t;
  // AC moves across the two 40-byte DDRAM lines, wrapping line 0 end <-> line 1 start
  function automatic logic [6:0] next_ac(input logic [6:0] ac, input logic inc);
    return inc ? (ac == WRAP_HI0 ? LINE1_BASE : ac == WRAP_HI1 ? LINE0_BASE : ac + 7'd1)
               : (ac == LINE0_BASE ? WRAP_HI1 : ac == LINE1_BASE ? WRAP_HI0 : ac - 7'd1);
  endfunction
endpackage

// File: rtl/lcd1602_monitor_if.sv
// lcd1602_monitor_if: HD44780 parallel write bus (en/rs/data)
interface lcd1602_monitor_if;
  logic       en;
  logic       rs;
  logic [7:0] data;
  modport master (output en, rs, data);
  modport slave (input en, rs, data);
endinterface

// File: rtl/lcd_strobe_sync.sv
// lcd_strobe_sync: synchronizes the LCD bus and flags each falling edge of en with the rs/data seen alongside it
module lcd_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       rs,
  input  logic [7:0] data,
  output logic       strobe,
  output logic       strobe_rs,
  output logic [7:0] strobe_data
);
  logic [SYNC_STAGES:0]        en_sr;
  logic [SYNC_STAGES-1:0]      rs_sr;
  logic [SYNC_STAGES-1:0][7:0] data_sr;
  // shift chains; en keeps one extra stage so the edge is judged on synchronized values only
  always_ff @(posedge clk)
    if (reset) begin
      en_sr   <= '0;
      rs_sr   <= '0;
      data_sr <= '0;
    end else begin
      en_sr   <= {en_sr[SYNC_STAGES-1:0], en};
      rs_sr   <= {rs_sr[SYNC_STAGES-2:0], rs};
      data_sr <= {data_sr[SYNC_STAGES-2:0], data};
    end
  assign strobe      = en_sr[SYNC_STAGES] & ~en_sr[SYNC_STAGES-1];
  assign strobe_rs   = rs_sr[SYNC_STAGES-1];
  assign strobe_data = data_sr[SYNC_STAGES-1];
endmodule

// File: rtl/lcd1602_monitor.sv
// lcd1602_monitor: decodes HD44780 writes into a 2x16 DDRAM shadow; define LCD_4BIT_MODE_EN for nibble-mode support
module lcd1602_monitor
  import lcd1602_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] BLANK_CHAR  = 8'h20
) (
  input  logic                    clk,
  input  logic                    reset,
  lcd1602_monitor_if.slave        lcd,
  input  logic [4:0]              rd_addr,
  output logic [7:0]              rd_char,
  output logic [6:0]              cursor,
  output logic                    display_on,
  output logic                    busy,
  output logic                    wr_pulse,
  output logic                    overflow
);
  state_t     state, state_n;
  logic       s_valid, s_rs;
  logic [7:0] s_data;
  logic       byte_ready, accept;
  logic [7:0] byte_in;
  logic       pend_valid, pend_rs;
  logic [7:0] pend_byte;
  logic       inc_mode;
  logic [4:0] fill_idx;
  logic [7:0] shadow [32];
  logic       is_setddram, is_dispctl, is_entry, is_home, is_clear;
  logic       in_line0, in_line1, wr_en;
  logic [4:0] wr_idx;
  logic [7:0] wr_val;

  lcd_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .reset(reset), .en(lcd.en), .rs(lcd.rs), .data(lcd.data),
    .strobe(s_valid), .strobe_rs(s_rs), .strobe_data(s_data)
  );

`ifdef LCD_4BIT_MODE_EN
  logic       nib_mode, nib_phase;
  logic [3:0] nib_hi;
  assign byte_ready = s_valid & (~nib_mode | nib_phase);
  assign byte_in    = nib_mode ? {nib_hi, s_data[7:4]} : s_data;
  // nibble assembly: phase 0 keeps the high half, phase 1 completes the byte; function set picks bus width
  always_ff @(posedge clk)
    if (reset) begin
      nib_mode  <= 1'b0;
      nib_phase <= 1'b0;
      nib_hi    <= '0;
    end else if (wr_pulse && !pend_rs && pend_byte[7:5] == CMD_FUNCSET[7:5]) begin
      nib_mode  <= ~pend_byte[4];
      nib_phase <= 1'b0;
    end else if (s_valid && nib_mode) begin
      nib_phase <= ~nib_phase;
      nib_hi    <= s_data[7:4];
    end
`else
  assign byte_ready = s_valid;
  assign byte_in    = s_data;
`endif

  assign accept = byte_ready & (~pend_valid | wr_pulse);

  // one-deep pending buffer; a byte that finds it full is lost and flagged
  always_ff @(posedge clk)
    if (reset) begin
      pend_valid <= 1'b0;
      pend_rs    <= 1'b0;
      pend_byte  <= '0;
      overflow   <= 1'b0;
    end else begin
      pend_valid <= accept | (pend_valid & ~wr_pulse);
      if (accept) begin
        pend_rs   <= s_rs;
        pend_byte <= byte_in;
      end
      if (byte_ready & ~accept) overflow <= 1'b1;
    end

  // command class from the highest set bit
  always_comb begin
    is_setddram = |(pend_byte & CMD_SETDDRAM);
    is_dispctl  = pend_byte[7:3] == CMD_DISPCTL[7:3];
    is_entry    = pend_byte[7:2] == CMD_ENTRY[7:2];
    is_home     = pend_byte[7:1] == CMD_HOME[7:1];
    is_clear    = pend_byte == CMD_CLEAR;
  end

  // state register; reset always restarts the blank fill from index 0
  always_ff @(posedge clk)
    state <= reset ? S_CLEAR : state_n;

  // next state
  always_comb
    state_n = state == S_IDLE   ? (pend_valid ? S_DECODE : S_IDLE)
            : state == S_DECODE ? (~pend_rs & is_clear ? S_CLEAR : S_IDLE)
            : (fill_idx == 5'd31 ? S_IDLE : S_CLEAR);

  // FSM outputs
  always_comb begin
    busy     = state == S_CLEAR;
    wr_pulse = state == S_DECODE;
  end

  // address counter, entry mode, display flag and fill index
  always_ff @(posedge clk)
    if (reset) begin
      cursor     <= LINE0_BASE;
      inc_mode   <= 1'b1;
      display_on <= 1'b0;
      fill_idx   <= '0;
    end else begin
      fill_idx <= busy ? fill_idx + 5'd1 : '0;
      if (wr_pulse) begin
        cursor     <= pend_rs ? next_ac(cursor, inc_mode) : is_setddram ? pend_byte[6:0]
                    : (is_home | is_clear) ? LINE0_BASE : cursor;
        inc_mode   <= pend_rs ? inc_mode : is_clear ? 1'b1 : is_entry ? pend_byte[1] : inc_mode;
        display_on <= ~pend_rs & is_dispctl ? pend_byte[2] : display_on;
      end
    end

  // single shadow write port: the blank fill or a data byte landing in a visible cell
  always_comb begin
    in_line0 = cursor < LINE0_BASE + LINE_CHARS;
    in_line1 = cursor >= LINE1_BASE && cursor < LINE1_BASE + LINE_CHARS;
    wr_en    = busy | (wr_pulse & pend_rs & (in_line0 | in_line1));
    wr_idx   = busy ? fill_idx : {in_line1, cursor[3:0]};
    wr_val   = busy ? BLANK_CHAR : pend_byte;
  end

  // shadow RAM with registered read; a same-cycle write to the read index returns old data
  always_ff @(posedge clk) begin
    if (wr_en) shadow[wr_idx] <= wr_val;
    rd_char <= reset ? 8'h00 : shadow[rd_addr];
  end
endmodule

// File: tb/tb_lcd1602_monitor.sv
// tb_lcd1602_monitor: scoreboard bench for lcd1602_monitor
module tb_lcd1602_monitor;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] rd_addr = '0;
  logic [7:0] rd_char;
  logic [6:0] cursor;
  logic       display_on, busy, wr_pulse, overflow;

  typedef struct packed {logic [6:0] ac; logic disp;} exp_t;
  exp_t sb[$];
  int   checks = 0, errors = 0, pulses = 0;
  logic [6:0] m_ac;
  logic       m_inc, m_disp;
  logic [7:0] m_sh [32];

  lcd1602_monitor_if bus();

  lcd1602_monitor dut (
    .clk(clk), .reset(reset), .lcd(bus), .rd_addr(rd_addr), .rd_char(rd_char),
    .cursor(cursor), .display_on(display_on), .busy(busy), .wr_pulse(wr_pulse), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_ac = 7'h00;
    m_inc = 1'b1;
    m_disp = 1'b0;
    for (int i = 0; i < 32; i++) m_sh[i] = 8'h20;
  endtask

  task automatic model_apply(input logic rs, input logic [7:0] d);
    if (rs) begin
      if (m_ac < 7'h10) m_sh[int'(m_ac)] = d;
      else if (m_ac >= 7'h40 && m_ac < 7'h50) m_sh[int'(m_ac) - 'h30] = d;
      if (m_inc) m_ac = m_ac == 7'h27 ? 7'h40 : m_ac == 7'h67 ? 7'h00 : m_ac + 7'd1;
      else m_ac = m_ac == 7'h00 ? 7'h67 : m_ac == 7'h40 ? 7'h27 : m_ac - 7'd1;
    end else if (d >= 8'h80) m_ac = d[6:0];
    else if (d < 8'h10) begin
      if (d >= 8'h08) m_disp = d[2];
      else if (d >= 8'h04) m_inc = d[1];
      else if (d >= 8'h02) m_ac = 7'h00;
      else if (d == 8'h01) begin
        m_ac = 7'h00;
        m_inc = 1'b1;
        for (int i = 0; i < 32; i++) m_sh[i] = 8'h20;
      end
    end
    sb.push_back('{m_ac, m_disp});
  endtask

  task automatic lcd_write(input logic rs, input logic [7:0] d);
    @(negedge clk);
    bus.rs = rs;
    bus.data = d;
    bus.en = 1'b1;
    repeat (4) @(negedge clk);
    bus.en = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic send(input logic rs, input logic [7:0] d);
    model_apply(rs, d);
    lcd_write(rs, d);
  endtask

  task automatic settle();
    int t = 0;
    while ((sb.size() != 0 || busy) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) check("settle_timeout", t, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic read_check(input int i);
    @(negedge clk);
    rd_addr = 5'(i);
    @(negedge clk);
    check($sformatf("cell%0d", i), rd_char, m_sh[i]);
  endtask

  task automatic check_all();
    for (int i = 0; i < 32; i++) read_check(i);
  endtask

  task automatic count_busy(input string tag);
    int t = 0, n = 0;
    while (!busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, n, 32);
  endtask

  // scoreboard consumer: one expected AC/display state per decoded write
  initial forever begin
    @(negedge clk);
    if (wr_pulse) begin
      pulses++;
      @(negedge clk);
      if (sb.size() == 0) check("unexpected_pulse", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("cursor", cursor, e.ac);
        check("display_on", display_on, e.disp);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    bus.en = 1'b0;
    bus.rs = 1'b0;
    bus.data = '0;
    m_reset();
    repeat (3) @(negedge clk);
    check("rst_rd_char", rd_char, 0);
    check("rst_busy", busy, 1);
    check("rst_wr_pulse", wr_pulse, 0);
    check("rst_cursor", cursor, 0);
    check("rst_overflow", overflow, 0);
    check("rst_display_on", display_on, 0);
    reset = 1'b0;
    settle();
    check_all();

    p0 = pulses;
    send(0, 8'h80); send(1, "N"); send(1, "O");
    settle();
    check("pulse_count", pulses - p0, 3);
    read_check(0); read_check(1);

    send(0, 8'hC0); send(1, "A");
    settle();
    read_check(16); read_check(0);

    send(0, 8'h0C);
    send(0, 8'h8F); send(1, "X"); send(1, "Y");
    settle();
    check_all();

    send(0, 8'hA7); send(1, "W"); send(1, "V");
    settle();
    read_check(16);

    send(0, 8'h06); send(0, 8'h04); send(0, 8'h80); send(1, "Z");
    settle();
    read_check(0);

    send(0, 8'h06);
    send(0, 8'h80);
    for (int i = 0; i < 16; i++) send(1, 8'h61 + 8'(i));
    send(0, 8'hC0);
    for (int i = 0; i < 16; i++) send(1, 8'h41 + 8'(i));
    settle();
    check_all();

    model_apply(0, 8'h01);
    fork
      begin
        lcd_write(0, 8'h01);
        model_apply(1, "Q");
        lcd_write(1, "Q");
        lcd_write(1, "R");
      end
      count_busy("clear_busy_cycles");
    join
    settle();
    check("overflow_set", overflow, 1);
    check_all();

    send(0, 8'h85); send(1, "K");
    settle();
    model_apply(0, 8'h01);
    lcd_write(0, 8'h01);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    count_busy("reset_busy_cycles");
    settle();
    check("post_rst_overflow", overflow, 0);
    check("post_rst_cursor", cursor, 0);
    check("post_rst_display_on", display_on, 0);
    check_all();

`ifdef LCD_4BIT_MODE_EN
    send(0, 8'h80);
    send(0, 8'h28);
    model_apply(1, 8'h4E);
    lcd_write(1, 8'h40);
    lcd_write(1, 8'hE0);
    settle();
    read_check(0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lcd1602_monitor.md
Name: lcd1602_monitor

Overview:
- Receiving end of the HD44780/1602 parallel write bus (en/rs/data) that the team's LCD string driver produces.
- Decodes the command and data writes and keeps a 32-character shadow of the visible 2x16 DDRAM window.
- Exposes the shadow through a read port, for self-checking benches and for on-board mirroring of the LCD contents (UART, 7-seg).

Parameters:
- SYNC_STAGES, 2, synchronizer depth on lcd_en/lcd_rs/lcd_data (minimum 2).
- BLANK_CHAR, 8'h20, fill value written by the Clear command and by reset.

Ports:
- clk  in  1  system clock (BOARD_CLOCKSPEED).
- reset  in  1  synchronous, active-high reset.
- lcd_en  in  1  LCD enable strobe; a write completes on its falling edge.
- lcd_rs  in  1  0 = command, 1 = data.
- lcd_data  in  8  LCD data bus.
- rd_addr  in  5  shadow index: 0-15 is line 0, 16-31 is line 1.
- rd_char  out  8  shadow[rd_addr], registered, 1-cycle latency.
- cursor  out  7  address counter (AC), HD44780 DDRAM address.
- display_on  out  1  D bit of the last Display Control command.
- busy  out  1  high while a Clear fill is in progress.
- wr_pulse  out  1  1-cycle pulse per decoded write (command or data).
- overflow  out  1  sticky flag; set when a strobe is lost during busy; cleared by reset only.

Behaviour:
- Reset: all 32 shadow entries = BLANK_CHAR via the CLEAR state; cursor = 0; increment mode = 1; display_on = 0; overflow = 0; wr_pulse = 0; rd_char = 0 on the first cycle.
- Reset mid-operation: abandons any fill or pending byte and restarts the clear from index 0.
- Strobe sampling:
  - lcd_en, lcd_rs and lcd_data pass through SYNC_STAGES flops.
  - A falling edge is detected on the synchronized en.
  - rs and data are captured from the synchronized copies in that same cycle.
  - Total input-to-decode latency is SYNC_STAGES+1 cycles.
- State machine: IDLE, DECODE, CLEAR.
  - IDLE -> DECODE: when a captured byte is pending.
  - DECODE: single cycle. Applies the byte, pulses wr_pulse, then goes to IDLE, or to CLEAR if the byte is command 0x01.
  - CLEAR: writes BLANK_CHAR to index 0..31 on consecutive cycles (32 cycles), busy = 1, then goes to IDLE.
- Pending buffer: one-deep. If a strobe arrives while the buffer is already occupied, the new byte is dropped and overflow is set.
- Command decode (rs = 0), highest set bit wins:
  - 0x80|a: AC = a[6:0].
  - 0x20-0x3F: function set; records DL only.
  - 0x08-0x0F: display_on = bit2.
  - 0x04-0x07: increment mode = bit1; the S bit is ignored.
  - 0x02/0x03: AC = 0.
  - 0x01: AC = 0, increment mode = 1, enter CLEAR.
  - 0x00: no-op, but still pulses wr_pulse.
- Data write (rs = 1):
  - If AC is in 0x00-0x0F, shadow[AC] = data.
  - If AC is in 0x40-0x4F, shadow[16+AC-0x40] = data.
  - Any other AC: the write is discarded, but AC still moves.
- AC update after each data write (2-line wrap rules):
  - Increment: 0x27 -> 0x40, 0x67 -> 0x00.
  - Decrement: 0x00 -> 0x67, 0x40 -> 0x27.
- Read port: rd_char is registered from shadow[rd_addr]. A write and a read to the same index in the same cycle returns the old value.

Optional Feature:
- Macro: LCD_4BIT_MODE_EN.
- With the macro defined:
  - A function-set command with DL = 0 switches the block to nibble mode.
  - In nibble mode each byte takes two strobes on lcd_data[7:4], high nibble first. A nibble phase flop tracks which half is expected.
  - A function set with DL = 1 decoded in nibble mode returns to 8-bit mode.
  - Reset forces 8-bit mode and phase 0.
- Without the macro: DL is ignored and every strobe is a full 8-bit byte.

Decomposition:
- Package lcd1602_pkg holds:
  - command opcode/mask constants: CLEAR, HOME, ENTRY, DISPCTL, FUNCSET, SETDDRAM;
  - line base addresses 0x00/0x40;
  - wrap bounds 0x27/0x67;
  - the LINE_CHARS = 16 constant;
  - the state enum typedef.
- Sub-module lcd_strobe_sync: synchronizer, falling-edge detect and capture, producing a byte + rs + valid.

Test Plan:
- Write cmd 0x80, then data 'N', 'O' -> shadow[0] = 0x4E, shadow[1] = 0x4F, cursor = 0x02; wr_pulse counted 3 times.
- Write cmd 0xC0, then 'A' -> shadow[16] = 0x41, cursor = 0x41; line 0 unchanged.
- Write cmd 0x8F, then 'X', 'Y' -> shadow[15] = 'X'; 'Y' at AC 0x10 dropped, no shadow change; cursor = 0x11.
- Write cmd 0x06, then 0x04, then cmd 0x80, then 'Z' -> shadow[0] = 'Z', cursor = 0x67 (decrement wrap).
- Fill all cells, then send cmd 0x01 -> busy high exactly 32 cycles; all rd_char = 0x20; cursor = 0. A strobe during busy is held; a second strobe during busy sets overflow.
- Assert reset at fill index 10 -> busy restarts and all cells = 0x20. With LCD_4BIT_MODE_EN: send 0x28 (8-bit strobe), then nibbles 4, E with rs = 1 -> shadow[0] = 0x4E.
